// File: rtl/codifica_hamming_tx.sv
// Hamming(15,11) encoder feeding a start/data/stop serial transmitter.
// A single-entry buffer holds the next encoded word so one frame can be
// in flight while the following word waits. Each serial bit lasts BIT_DIV
// clock cycles, and frames are sent back to back whenever the buffer is full.

module codifica_hamming_tx #(
  parameter int BIT_DIV = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [10:0] dados,
  output logic        serial_out,
  output logic        busy,
  output logic [14:0] palavra,
  output logic        frame_done
);

  localparam logic [7:0] DIV_LAST = 8'(BIT_DIV - 1);
  localparam logic [3:0] BIT_LAST = 4'd14;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // Data bits occupy the non-power-of-two positions; parity bits give
  // even parity over the positions whose index has the matching bit set.
  function automatic logic [14:0] hamming_encode(input logic [10:0] d);
    logic [14:0] cw;
    cw     = 15'd0;
    cw[2]  = d[0];
    cw[4]  = d[1];
    cw[5]  = d[2];
    cw[6]  = d[3];
    cw[8]  = d[4];
    cw[9]  = d[5];
    cw[10] = d[6];
    cw[11] = d[7];
    cw[12] = d[8];
    cw[13] = d[9];
    cw[14] = d[10];
    cw[0]  = cw[2] ^ cw[4] ^ cw[6] ^ cw[8] ^ cw[10] ^ cw[12] ^ cw[14];
    cw[1]  = cw[2] ^ cw[5] ^ cw[6] ^ cw[9] ^ cw[10] ^ cw[13] ^ cw[14];
    cw[3]  = cw[4] ^ cw[5] ^ cw[6] ^ cw[11] ^ cw[12] ^ cw[13] ^ cw[14];
    cw[7]  = ^cw[14:8];
    return cw;
  endfunction

  state_t      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [3:0]  bit_q, bit_d;
  logic [14:0] shift_q, shift_d;
  logic [14:0] palavra_q, palavra_d;
  logic        buf_full_q, buf_full_d;
  logic [14:0] buf_word_q, buf_word_d;
  logic        in_ready_q;
  logic        serial_q, serial_d;
  logic        busy_q, busy_d;
  logic        frame_done_q, frame_done_d;
  logic        accept_s, load_s, last_div_s;

  // Handshake: accept only into an empty buffer; a load by the FSM empties it.
  always_comb begin
    accept_s   = in_valid & in_ready_q;
    buf_full_d = buf_full_q;
    buf_word_d = buf_word_q;
    if (accept_s) begin
      buf_full_d = 1'b1;
      buf_word_d = hamming_encode(dados);
    end else if (load_s) begin
      buf_full_d = 1'b0;
    end else begin
      buf_full_d = buf_full_q;
    end
  end

  // Frame sequencer: bit-period divider, bit counter and shift register.
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    palavra_d  = palavra_q;
    load_s     = 1'b0;
    last_div_s = (div_q == DIV_LAST);
    case (state_q)
      S_IDLE: begin
        if (buf_full_q) begin
          load_s    = 1'b1;
          state_d   = S_START;
          div_d     = 8'd0;
          bit_d     = 4'd0;
          shift_d   = buf_word_q;
          palavra_d = buf_word_q;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (last_div_s) begin
          state_d = S_DATA;
          div_d   = 8'd0;
          bit_d   = 4'd0;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      S_DATA: begin
        if (last_div_s) begin
          div_d   = 8'd0;
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) begin
            state_d = S_STOP;
            bit_d   = 4'd0;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      S_STOP: begin
        if (!last_div_s) begin
          div_d = div_q + 8'd1;
        end else if (buf_full_q) begin
          // Next word is already waiting: start it with no idle gap.
          load_s    = 1'b1;
          state_d   = S_START;
          div_d     = 8'd0;
          bit_d     = 4'd0;
          shift_d   = buf_word_q;
          palavra_d = buf_word_q;
        end else begin
          state_d = S_IDLE;
          div_d   = 8'd0;
        end
      end
      default: begin
        state_d = S_IDLE;
        div_d   = 8'd0;
        bit_d   = 4'd0;
      end
    endcase
  end

  // Output decode from the next state so the outputs can be registered.
  always_comb begin
    serial_d     = 1'b1;
    busy_d       = 1'b0;
    frame_done_d = 1'b0;
    case (state_d)
      S_START: begin
        serial_d = 1'b0;
        busy_d   = 1'b1;
      end
      S_DATA: begin
        serial_d = shift_d[0];
        busy_d   = 1'b1;
      end
      S_STOP: begin
        serial_d     = 1'b1;
        busy_d       = 1'b1;
        frame_done_d = (div_d == DIV_LAST);
      end
      default: begin
        serial_d     = 1'b1;
        busy_d       = 1'b0;
        frame_done_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      div_q        <= 8'd0;
      bit_q        <= 4'd0;
      shift_q      <= 15'd0;
      palavra_q    <= 15'd0;
      buf_full_q   <= 1'b0;
      buf_word_q   <= 15'd0;
      in_ready_q   <= 1'b0;
      serial_q     <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      palavra_q    <= palavra_d;
      buf_full_q   <= buf_full_d;
      buf_word_q   <= buf_word_d;
      in_ready_q   <= ~buf_full_d;
      serial_q     <= serial_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign serial_out = serial_q;
  assign busy       = busy_q;
  assign palavra    = palavra_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_codifica_hamming_tx.sv
// Bench for codifica_hamming_tx: three instances (BIT_DIV 4, 1, 3), directed
// checks on the first, randomized traffic on the other two. A line monitor
// compares every frame cycle against a scoreboard of accepted words and a
// position-based Hamming reference encoder/corrector.

module tb_codifica_hamming_tx;

  localparam int NDUT = 3;
  localparam int QSZ  = 8;

  function automatic int div_of(input int i);
    return (i == 0) ? 4 : ((i == 1) ? 1 : 3);
  endfunction

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid   [NDUT];
  logic [10:0] dados      [NDUT];
  logic        in_ready   [NDUT];
  logic        serial_out [NDUT];
  logic        busy       [NDUT];
  logic [14:0] palavra    [NDUT];
  logic        frame_done [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    codifica_hamming_tx #(.BIT_DIV(div_of(g))) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid[g]),
      .in_ready   (in_ready[g]),
      .dados      (dados[g]),
      .serial_out (serial_out[g]),
      .busy       (busy[g]),
      .palavra    (palavra[g]),
      .frame_done (frame_done[g])
    );
  end

  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Reference code: position p (1..15) carries data unless p is a power of
  // two; parity bit at position 2^k covers every position with bit k set.
  function automatic logic [14:0] ref_encode(input logic [10:0] d);
    logic [14:0] cw;
    int          j;
    logic        par;
    cw = 15'd0;
    j  = 0;
    for (int pos = 1; pos <= 15; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        if (((d >> j) & 11'd1) != 11'd0) cw = cw | (15'd1 << (pos - 1));
        j++;
      end
    end
    for (int p = 1; p <= 8; p = p * 2) begin
      par = 1'b0;
      for (int pos = 1; pos <= 15; pos++)
        if ((pos & p) != 0 && pos != p && ((cw >> (pos - 1)) & 15'd1) != 15'd0) par = ~par;
      if (par) cw = cw | (15'd1 << (p - 1));
    end
    return cw;
  endfunction

  function automatic int syndrome(input logic [14:0] cw);
    int s;
    s = 0;
    for (int pos = 1; pos <= 15; pos++)
      if (((cw >> (pos - 1)) & 15'd1) != 15'd0) s = s ^ pos;
    return s;
  endfunction

  function automatic logic [10:0] ref_decode(input logic [14:0] cw_in);
    logic [14:0] cw;
    logic [10:0] d;
    int          s;
    int          j;
    cw = cw_in;
    s  = syndrome(cw);
    if (s != 0) cw = cw ^ (15'd1 << (s - 1));
    d = 11'd0;
    j = 0;
    for (int pos = 1; pos <= 15; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        if (((cw >> (pos - 1)) & 15'd1) != 15'd0) d = d | (11'd1 << j);
        j++;
      end
    end
    return d;
  endfunction

  // Scoreboard of accepted words and per-instance line-monitor state.
  logic [10:0] expq [NDUT][QSZ];
  int          q_head [NDUT];
  int          q_tail [NDUT];
  int          n_acc [NDUT];
  int          n_frames [NDUT];
  int          idle_err [NDUT];
  bit          in_frame [NDUT];
  int          kcnt [NDUT];
  int          ferr [NDUT];
  logic [14:0] rx [NDUT];
  logic [14:0] cur_cw [NDUT];
  logic [10:0] cur_d [NDUT];

  task automatic mon_step(input int i);
    int   d;
    int   k;
    int   nok;
    logic exp_line;
    d = div_of(i);
    if (!rst_n) begin
      in_frame[i] = 1'b0;
      q_head[i]   = q_tail[i];
      return;
    end
    if (!in_frame[i]) begin
      if (serial_out[i] == 1'b0) begin
        check_eq("frame_queued", 32'(q_head[i] != q_tail[i]), 32'd1);
        if (q_head[i] != q_tail[i]) begin
          cur_d[i] = expq[i][q_head[i] % QSZ];
          q_head[i]++;
        end else begin
          cur_d[i] = 11'd0;
        end
        cur_cw[i]   = ref_encode(cur_d[i]);
        in_frame[i] = 1'b1;
        kcnt[i]     = 0;
        ferr[i]     = 0;
        rx[i]       = 15'd0;
      end else if (busy[i] !== 1'b0 || frame_done[i] !== 1'b0) begin
        idle_err[i]++;
      end
    end
    if (in_frame[i]) begin
      k = kcnt[i];
      if (k < d) exp_line = 1'b0;
      else if (k < 16 * d) exp_line = 1'((cur_cw[i] >> ((k - d) / d)) & 15'd1);
      else exp_line = 1'b1;
      if (serial_out[i] !== exp_line || busy[i] !== 1'b1 ||
          frame_done[i] !== (k == 17 * d - 1) || palavra[i] !== cur_cw[i])
        ferr[i]++;
      if (k >= d && k < 16 * d && ((k - d) % d) == 0)
        rx[i] = rx[i] | (15'(serial_out[i]) << ((k - d) / d));
      if (k == 17 * d - 1) begin
        check_eq("frame_line", 32'(ferr[i]), 32'd0);
        check_eq("frame_decode", 32'(ref_decode(rx[i])), 32'(cur_d[i]));
        check_eq("frame_syndrome", 32'(syndrome(palavra[i])), 32'd0);
        nok = 0;
        for (int b = 0; b < 15; b++)
          if (ref_decode(palavra[i] ^ (15'd1 << b)) == cur_d[i]) nok++;
        check_eq("frame_flips", 32'(nok), 32'd15);
        in_frame[i] = 1'b0;
        n_frames[i]++;
      end else begin
        kcnt[i] = k + 1;
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < NDUT; i++) mon_step(i);
    end
  end

  task automatic send(input int idx, input logic [10:0] d, output int acc);
    int t;
    t   = 0;
    acc = -1;
    @(negedge clk);
    in_valid[idx] = 1'b1;
    dados[idx]    = d;
    while (in_ready[idx] !== 1'b1 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check_eq("send_ready_seen", 32'(t < 5000), 32'd1);
    if (t >= 5000) return;
    @(posedge clk);
    #1;
    expq[idx][q_tail[idx] % QSZ] = d;
    q_tail[idx]++;
    n_acc[idx]++;
    acc = cyc_cnt;
  endtask

  task automatic release_in(input int idx, input int gap);
    @(negedge clk);
    in_valid[idx] = 1'b0;
    dados[idx]    = 11'($urandom);
    repeat (gap) begin
      @(negedge clk);
      dados[idx] = 11'($urandom);
    end
  endtask

  task automatic wait_fd(input int idx, input int maxc, output int at);
    int t;
    t  = 0;
    at = -1;
    while (t < maxc) begin
      @(posedge clk);
      #1;
      t++;
      if (frame_done[idx] === 1'b1) begin
        at = cyc_cnt;
        break;
      end
    end
    check_eq("frame_done_seen", 32'(at >= 0), 32'd1);
  endtask

  task automatic rand_traffic(input int idx, input int nwords, input int maxgap);
    int a;
    int g;
    for (int n = 0; n < nwords; n++) begin
      send(idx, 11'($urandom), a);
      g = $urandom_range(maxgap);
      if (g != 0 || n == nwords - 1) release_in(idx, g);
    end
  endtask

  initial begin
    int          acc;
    int          at;
    int          nfd;
    int          last_fd;
    int          bad;
    int          t;
    bit          pending;
    logic [10:0] wd [2];
    logic [14:0] wc [2];
    logic [10:0] wr;

    wd[0] = 11'h7FF; wc[0] = 15'h7FFF;
    wd[1] = 11'h001; wc[1] = 15'h0007;
    for (int i = 0; i < NDUT; i++) begin
      in_valid[i] = 1'b0;
      dados[i]    = 11'd0;
    end

    // Reset values while rst_n is held low.
    repeat (3) @(negedge clk);
    for (int i = 0; i < NDUT; i++) begin
      check_eq("rst_in_ready", 32'(in_ready[i]), 32'd0);
      check_eq("rst_serial", 32'(serial_out[i]), 32'd1);
      check_eq("rst_busy", 32'(busy[i]), 32'd0);
      check_eq("rst_palavra", 32'(palavra[i]), 32'd0);
      check_eq("rst_frame_done", 32'(frame_done[i]), 32'd0);
    end
    #2 rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NDUT; i++) check_eq("post_rst_in_ready", 32'(in_ready[i]), 32'd1);

    // All-zero word: latency and exact frame length.
    send(0, 11'h000, acc);
    check_eq("accept_in_ready_low", 32'(in_ready[0]), 32'd0);
    check_eq("accept_serial_idle", 32'(serial_out[0]), 32'd1);
    release_in(0, 0);
    @(posedge clk);
    #1;
    check_eq("start_latency_serial", 32'(serial_out[0]), 32'd0);
    check_eq("start_latency_busy", 32'(busy[0]), 32'd1);
    check_eq("palavra_000", 32'(palavra[0]), 32'h0000);
    wait_fd(0, 200, at);
    check_eq("frame_len_000", 32'(at - acc), 32'd68);

    // Spec-listed codewords.
    for (int n = 0; n < 2; n++) begin
      send(0, wd[n], acc);
      release_in(0, 0);
      wait_fd(0, 200, at);
      check_eq("palavra_const", 32'(palavra[0]), 32'(wc[n]));
      check_eq("frame_len_const", 32'(at - acc), 32'd68);
    end

    // Three words with in_valid held high: back-to-back frames.
    nfd     = 0;
    last_fd = -1;
    acc     = 0;
    fork
      begin
        int a1;
        int a2;
        send(0, 11'h2A5, acc);
        check_eq("b2b_in_ready_low", 32'(in_ready[0]), 32'd0);
        send(0, 11'h15A, a1);
        send(0, 11'h3C3, a2);
        release_in(0, 0);
      end
      begin
        for (int c = 0; c < 400 && nfd < 3; c++) begin
          @(posedge clk);
          #1;
          if (frame_done[0] === 1'b1) begin
            nfd++;
            last_fd = cyc_cnt;
          end
        end
      end
    join
    check_eq("b2b_pulses", 32'(nfd), 32'd3);
    check_eq("b2b_span", 32'(last_fd - acc), 32'd204);

    // Reset during DATA bit 7 with the buffer full.
    send(0, 11'h6B1, acc);
    release_in(0, 0);
    send(0, 11'h0F0, at);
    release_in(0, 0);
    while (cyc_cnt < acc + 34) @(negedge clk);
    check_eq("pre_rst_busy", 32'(busy[0]), 32'd1);
    check_eq("pre_rst_in_ready", 32'(in_ready[0]), 32'd0);
    #2 rst_n = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_serial", 32'(serial_out[0]), 32'd1);
    check_eq("mid_rst_busy", 32'(busy[0]), 32'd0);
    check_eq("mid_rst_in_ready", 32'(in_ready[0]), 32'd0);
    check_eq("mid_rst_frame_done", 32'(frame_done[0]), 32'd0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_ready_again", 32'(in_ready[0]), 32'd1);
    bad = 0;
    repeat (80) begin
      @(negedge clk);
      if (serial_out[0] !== 1'b1 || frame_done[0] !== 1'b0 || busy[0] !== 1'b0) bad++;
    end
    check_eq("mid_rst_quiet", 32'(bad), 32'd0);
    wr = 11'h4D2;
    send(0, wr, acc);
    release_in(0, 0);
    wait_fd(0, 200, at);
    check_eq("post_rst_palavra", 32'(palavra[0]), 32'(ref_encode(wr)));
    check_eq("post_rst_len", 32'(at - acc), 32'd68);

    // Randomized traffic with random in_valid gaps on BIT_DIV 1 and 3.
    fork
      rand_traffic(1, 600, 20);
      rand_traffic(2, 400, 60);
    join

    t       = 0;
    pending = 1'b1;
    while (pending && t < 2000) begin
      @(negedge clk);
      t++;
      pending = 1'b0;
      for (int i = 0; i < NDUT; i++)
        if (in_frame[i] || q_head[i] != q_tail[i] || busy[i] !== 1'b0) pending = 1'b1;
    end
    check_eq("drained", 32'(pending), 32'd0);
    for (int i = 0; i < NDUT; i++) begin
      check_eq("idle_line", 32'(idle_err[i]), 32'd0);
      check_eq("frame_count", 32'(n_frames[i]), 32'(n_acc[i] - ((i == 0) ? 2 : 0)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, vectors %0d", n_vec);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/codifica_hamming_tx.md
CODIFICA_HAMMING_TX -- requirements
Module: codifica_hamming_tx

Interface
REQ-001 SHALL have parameter: BIT_DIV, 4, clock cycles per serial bit (legal range 1..255).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: in_valid  input  1  dados holds a word to encode.
REQ-005 SHALL have port: in_ready  output  1  block can accept a word this cycle.
REQ-006 SHALL have port: dados  input  11  data bits d10..d0.
REQ-007 SHALL have port: serial_out  output  1  registered serial line; idle level 1.
REQ-008 SHALL have port: busy  output  1  a frame is in transmission (state != IDLE).
REQ-009 SHALL have port: palavra  output  15  codeword of the frame currently or last transmitted.
REQ-010 SHALL have port: frame_done  output  1  one-cycle pulse at the end of a frame.

Function
REQ-011 SHALL encode Hamming(15,11), codeword index i = position i+1: d0->[2], d1->[4], d2->[5], d3->[6], d4->[8], d5->[9], d6->[10], d7->[11], d8->[12], d9->[13], d10->[14].
REQ-012 SHALL set parity bits: [0] = XOR of [2,4,6,8,10,12,14]; [1] = XOR of [2,5,6,9,10,13,14]; [3] = XOR of [4,5,6,11,12,13,14]; [7] = XOR of [8..14] (even parity; zero syndrome at decoder).
REQ-013 SHALL hold one encoded word in a single-entry buffer; in_ready = buffer empty, registered; no same-cycle drain-and-refill.
REQ-014 SHALL accept a word when in_valid and in_ready are high at a rising edge; word encoded and stored in buffer at that edge.
REQ-015 SHALL ignore dados when in_valid is low or in_ready is low; no word lost or duplicated.
REQ-016 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-017 IDLE: if buffer full, at next edge load shift register and palavra from buffer, empty buffer, go START; else stay IDLE.
REQ-018 START: serial_out = 0 for BIT_DIV cycles, then DATA.
REQ-019 DATA: 15 bits LSB first (index 0 first), each BIT_DIV cycles, 4-bit bit counter 0..14, then STOP.
REQ-020 STOP: serial_out = 1 for BIT_DIV cycles; frame_done high in the last STOP cycle only.
REQ-021 At end of STOP: buffer full -> load and go START at same edge (no idle gap); else go IDLE.
REQ-022 Frame length SHALL be exactly 17*BIT_DIV cycles; serial_out changes only at bit boundaries.
REQ-023 Latency: word accepted at edge N into empty buffer with FSM in IDLE -> serial_out low from edge N+1.
REQ-024 Buffer SHALL refill while a frame is in flight, so one frame transmits while next word waits.
REQ-025 BIT_DIV = 1 SHALL work: one cycle per bit, frame_done still one cycle wide.

Reset
REQ-026 While rst_n low at an edge: FSM IDLE, buffer empty, in_ready 0, serial_out 1, busy 0, palavra 0, frame_done 0, counters 0.
REQ-027 First edge with rst_n high: in_ready 1.
REQ-028 Reset mid-frame SHALL abort frame and discard buffered word; serial_out 1 after the reset edge; no frame_done.

Verification
REQ-029 dados=11'h000 accepted, BIT_DIV=4 -> palavra 15'h0000; line: 4 cycles 0, 60 cycles 0, 4 cycles 1; frame_done once at cycle 68.
REQ-030 dados=11'h7FF -> palavra 15'h7FFF; dados=11'h001 -> palavra 15'h0007; serial bits match LSB-first order.
REQ-031 Three words driven with in_valid held high -> in_ready low after first accept; second frame START directly follows first STOP; all three frames in order, no gaps, 3 frame_done pulses.
REQ-032 Random 1000 words, random in_valid gaps, BIT_DIV in {1,3} -> each sampled frame passed through a reference corrector returns the original dados; every single-bit flip of palavra also corrected.
REQ-033 rst_n low for 1 cycle during DATA bit 7 with buffer full -> serial_out 1, busy 0, in_ready 0 then 1, no frame_done, next accepted word transmits correctly.
